instr_reg_seq: RTL and testbench

Parametrised instruction register and multi-cycle sequencer for the CPU fetch/decode path. It accepts an instruction word through a valid/ready handshake and splits it into opcode and address fields. It then holds those fields stable while a per-opcode cycle counter runs down, and tells the control unit when the instruction starts and finishes. Compared with the earlier fixed 8-bit register it adds configurable field widths and cycle table, an input handshake, stall, flush, and status outputs.

---
 rtl/instr_reg_seq.sv | 91 +++++++++
 tb/tb_instr_reg_seq.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_reg_seq.sv
// Instruction register and multi-cycle sequencer: latches opcode/address on a valid/ready accept,
// then runs a per-opcode cycle counter down to zero, pulsing issue at start and done at finish.
module instr_reg_seq #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned OP_W   = 3,
  parameter int unsigned CNT_W  = 3,
  parameter logic [(2**OP_W)*CNT_W-1:0] CYCLES = 24'o34555520
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     instr_valid_i,
  input  logic [DATA_W-1:0]        instr_data_i,
  output logic                     instr_ready_o,
  input  logic                     stall_i,
  input  logic                     flush_i,
  output logic [OP_W-1:0]          opcode_o,
  output logic [DATA_W-OP_W-1:0]   address_o,
  output logic                     issue_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [CNT_W-1:0]         cycles_left_o
);

  localparam int unsigned ADDR_W = DATA_W - OP_W;

  logic [OP_W-1:0]   op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              issue_q, issue_d;
  logic              done_q, done_d;

  logic [OP_W-1:0]   op_in;
  logic [ADDR_W-1:0] addr_in;
  logic [CNT_W-1:0]  cnt_load;
  logic              ready;
  logic              accept;

  assign op_in    = instr_data_i[DATA_W-1 -: OP_W];
  assign addr_in  = instr_data_i[ADDR_W-1:0];
  assign cnt_load = CYCLES[int'(op_in) * int'(CNT_W) +: CNT_W];

  assign ready  = (cnt_q == '0) && !stall_i && !flush_i;
  assign accept = instr_valid_i && ready;

  // flush beats stall, stall beats accept/decrement; accept and decrement are exclusive by cnt_q
  always_comb begin
    op_d    = op_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    issue_d = 1'b0;
    done_d  = 1'b0;
    if (flush_i) begin
      cnt_d = '0;
    end else if (!stall_i) begin
      if (accept) begin
        op_d    = op_in;
        addr_d  = addr_in;
        cnt_d   = cnt_load;
        issue_d = 1'b1;
      end else if (cnt_q != '0) begin
        cnt_d  = cnt_q - 1'b1;
        done_d = (cnt_q == CNT_W'(1));
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      op_q    <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      issue_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      op_q    <= op_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      issue_q <= issue_d;
      done_q  <= done_d;
    end
  end

  assign instr_ready_o = ready;
  assign opcode_o      = op_q;
  assign address_o     = addr_q;
  assign issue_o       = issue_q;
  assign busy_o        = (cnt_q != '0);
  assign done_o        = done_q;
  assign cycles_left_o = cnt_q;

endmodule

// File: tb/tb_instr_reg_seq.sv
// Self-checking bench for instr_reg_seq: directed scenarios plus randomized traffic against a
// cycle-level reference model of the accept/count/flush/stall rules.
module tb_instr_reg_seq;

  logic       clk = 1'b0;
  logic       rst_n, valid, stall, flush;
  logic [7:0] data;

  logic       ready, issue, busy, done;
  logic [2:0] opcode, cycles_left;
  logic [4:0] address;

  logic       u2_ready, u2_issue, u2_busy, u2_done;
  logic [2:0] u2_opcode, u2_cycles_left;
  logic [4:0] u2_address;

  always #5 clk = ~clk;

  instr_reg_seq dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .instr_valid_i (valid),
    .instr_data_i  (data),
    .instr_ready_o (ready),
    .stall_i       (stall),
    .flush_i       (flush),
    .opcode_o      (opcode),
    .address_o     (address),
    .issue_o       (issue),
    .busy_o        (busy),
    .done_o        (done),
    .cycles_left_o (cycles_left)
  );

  // opcode 5 lengthened to 7 cycles
  instr_reg_seq #(.CYCLES(24'o34755520)) dut2 (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .instr_valid_i (valid),
    .instr_data_i  (data),
    .instr_ready_o (u2_ready),
    .stall_i       (stall),
    .flush_i       (flush),
    .opcode_o      (u2_opcode),
    .address_o     (u2_address),
    .issue_o       (u2_issue),
    .busy_o        (u2_busy),
    .done_o        (u2_done),
    .cycles_left_o (u2_cycles_left)
  );

  int n_checks = 0;
  int n_fail   = 0;

  int tbl[8] = '{0, 2, 5, 5, 5, 5, 4, 3};
  int m_cnt = 0, m_op = 0, m_addr = 0;
  bit m_issue = 1'b0, m_done = 1'b0;

  logic [14:0] act_vec;
  assign act_vec = {opcode, address, issue, busy, done, cycles_left, ready};

  function automatic logic [14:0] exp_vec();
    logic rdy_e;
    logic [2:0] op_e, cnt_e;
    logic [4:0] addr_e;
    rdy_e  = (m_cnt == 0) && !stall && !flush;
    op_e   = 3'(m_op);
    addr_e = 5'(m_addr);
    cnt_e  = 3'(m_cnt);
    return {op_e, addr_e, m_issue, m_cnt != 0, m_done, cnt_e, rdy_e};
  endfunction

  task automatic drive(input logic v, input logic [7:0] d, input logic s, input logic f);
    valid = v;
    data  = d;
    stall = s;
    flush = f;
  endtask

  // advance one edge, update the reference model, then settle before sampling
  task automatic tick();
    bit rdy;
    @(posedge clk);
    rdy = (m_cnt == 0) && !stall && !flush;
    if (!rst_n) begin
      m_cnt = 0; m_op = 0; m_addr = 0; m_issue = 0; m_done = 0;
    end else begin
      m_issue = 0;
      m_done  = 0;
      if (flush) begin
        m_cnt = 0;
      end else if (!stall) begin
        if (valid && rdy) begin
          m_op    = int'(data) / 32;
          m_addr  = int'(data) % 32;
          m_cnt   = tbl[m_op];
          m_issue = 1;
        end else if (m_cnt > 0) begin
          m_cnt  = m_cnt - 1;
          m_done = (m_cnt == 0);
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if (act_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL reset cyc%0d: got %h expected %h", i, act_vec, exp_vec());
      end
      n_checks++;
      if ({opcode, address, issue, busy, done, cycles_left} !== 14'h0) begin
        n_fail++;
        $display("FAIL reset_zero cyc%0d: got %h expected 0", i,
                 {opcode, address, issue, busy, done, cycles_left});
      end
    end
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: got %b expected 1", ready);
    end
    tick();
  endtask

  task automatic test_accept_hold();
    drive(1'b1, 8'h2A, 1'b0, 1'b0);
    tick();
    n_checks++;
    if ({issue, cycles_left, opcode, address} !== {1'b1, 3'd2, 3'd1, 5'h0A}) begin
      n_fail++;
      $display("FAIL accept_first: got %h expected %h", {issue, cycles_left, opcode, address},
               {1'b1, 3'd2, 3'd1, 5'h0A});
    end
    drive(1'b1, 8'hC3, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if (act_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL accept_run cyc%0d: got %h expected %h", i, act_vec, exp_vec());
      end
    end
    n_checks++;
    if ({done, ready, opcode, cycles_left} !== {1'b1, 1'b1, 3'd1, 3'd0}) begin
      n_fail++;
      $display("FAIL accept_done: got %h expected %h", {done, ready, opcode, cycles_left},
               {1'b1, 1'b1, 3'd1, 3'd0});
    end
    tick();
    n_checks++;
    if ({opcode, address, issue, cycles_left} !== {3'd6, 5'h03, 1'b1, 3'd4}) begin
      n_fail++;
      $display("FAIL accept_second: got %h expected %h", {opcode, address, issue, cycles_left},
               {3'd6, 5'h03, 1'b1, 3'd4});
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      tick();
      n_checks++;
      if (act_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL accept_drain cyc%0d: got %h expected %h", i, act_vec, exp_vec());
      end
    end
  endtask

  task automatic test_zero_cycle();
    logic [7:0] words[3] = '{8'h05, 8'h1F, 8'h00};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, words[i], 1'b0, 1'b0);
      tick();
      n_checks++;
      if ({issue, busy, done, ready, address} !== {4'b1001, words[i][4:0]}) begin
        n_fail++;
        $display("FAIL zero_cycle w%0d: got %h expected %h", i,
                 {issue, busy, done, ready, address}, {4'b1001, words[i][4:0]});
      end
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    n_checks++;
    if (act_vec !== exp_vec()) begin
      n_fail++;
      $display("FAIL zero_cycle_end: got %h expected %h", act_vec, exp_vec());
    end
  endtask

  task automatic test_stall();
    int done_edge = -1;
    drive(1'b1, 8'h5F, 1'b0, 1'b0);
    tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    for (int e = 1; e <= 12; e++) begin
      stall = (e >= 3 && e <= 5);
      tick();
      if (done === 1'b1 && done_edge < 0) done_edge = e;
      n_checks++;
      if (act_vec !== exp_vec() || opcode !== 3'd2 || address !== 5'h1F) begin
        n_fail++;
        $display("FAIL stall edge%0d: got %h expected %h", e, act_vec, exp_vec());
      end
    end
    stall = 1'b0;
    n_checks++;
    if (done_edge != 8) begin
      n_fail++;
      $display("FAIL stall_done_edge: got %0d expected 8", done_edge);
    end
  endtask

  task automatic test_flush();
    drive(1'b1, 8'hE7, 1'b0, 1'b0);
    tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    n_checks++;
    if (cycles_left !== 3'd2) begin
      n_fail++;
      $display("FAIL flush_pre: got %0d expected 2", cycles_left);
    end
    flush = 1'b1;
    tick();
    n_checks++;
    if ({cycles_left, done, busy, opcode, ready} !== {3'd0, 1'b0, 1'b0, 3'd7, 1'b0}) begin
      n_fail++;
      $display("FAIL flush_edge: got %h expected %h", {cycles_left, done, busy, opcode, ready},
               {3'd0, 1'b0, 1'b0, 3'd7, 1'b0});
    end
    flush = 1'b0;
    #1;
    n_checks++;
    if (ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_ready: got %b expected 1", ready);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (act_vec !== exp_vec() || done !== 1'b0) begin
        n_fail++;
        $display("FAIL flush_after cyc%0d: got %h expected %h", i, act_vec, exp_vec());
      end
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 8'hA1, 1'b0, 1'b0);
    tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    tick();
    n_checks++;
    if (cycles_left !== 3'd3) begin
      n_fail++;
      $display("FAIL reset_mid_pre: got %0d expected 3", cycles_left);
    end
    rst_n = 1'b0;
    tick();
    n_checks++;
    if ({opcode, address, issue, busy, done, cycles_left} !== 14'h0) begin
      n_fail++;
      $display("FAIL reset_mid: got %h expected 0",
               {opcode, address, issue, busy, done, cycles_left});
    end
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (act_vec !== exp_vec() || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_after: got %h expected %h", act_vec, exp_vec());
    end
  endtask

  task automatic test_override();
    int busy_cycles = 0;
    int done_count  = 0;
    drive(1'b1, 8'hA1, 1'b0, 1'b0);
    tick();
    n_checks++;
    if ({u2_opcode, u2_cycles_left} !== {3'd5, 3'd7}) begin
      n_fail++;
      $display("FAIL override_load: got %h expected %h", {u2_opcode, u2_cycles_left},
               {3'd5, 3'd7});
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    if (u2_busy === 1'b1) busy_cycles++;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (u2_busy === 1'b1) busy_cycles++;
      if (u2_done === 1'b1) done_count++;
      n_checks++;
      if (act_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL override_main cyc%0d: got %h expected %h", i, act_vec, exp_vec());
      end
    end
    n_checks++;
    if (busy_cycles != 7 || done_count != 1) begin
      n_fail++;
      $display("FAIL override_busy: got busy=%0d done=%0d expected busy=7 done=1",
               busy_cycles, done_count);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom % 4) != 0, 8'($urandom), ($urandom % 5) == 0, ($urandom % 23) == 0);
      rst_n = ($urandom % 200) != 0;
      tick();
      n_checks++;
      if (act_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL random cyc%0d: got %h expected %h", i, act_vec, exp_vec());
      end
    end
    rst_n = 1'b1;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    test_reset();
    test_accept_hold();
    test_zero_cycle();
    test_stall();
    test_flush();
    test_reset_mid();
    test_override();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
